// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter in front of a shared combinational binary-to-BCD converter.
// Optional build macro BCD_CONV_RANGE_CHK_EN clamps operands above 9999 and pulses err.
module bcd_conv_arbiter #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [55:0] bin_in,
  output logic [3:0]  ack,
  output logic [15:0] bcd_out,
  output logic        bcd_valid,
  output logic [1:0]  bcd_id,
  output logic        busy,
  output logic        err,
  output logic [13:0] conv_bin,
  input  logic [3:0]  conv_thousands,
  input  logic [3:0]  conv_hundreds,
  input  logic [3:0]  conv_tens,
  input  logic [3:0]  conv_ones
);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic [1:0]  last_grant;
  logic [1:0]  owner;
  logic [1:0]  grant_idx;
  logic        grant_fire;
  logic        capture_fire;
  logic [13:0] slice [4];
  logic [13:0] sel_bin;
  logic [13:0] load_bin;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_slice
      assign slice[gi] = bin_in[14*gi +: 14];
    end
  endgenerate

  // Search upward starting just after the previous winner.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    grant_idx = last_grant;
    found     = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = last_grant + 2'(i);
      if (!found && req[idx]) begin
        grant_idx = idx;
        found     = 1'b1;
      end
    end
  end

  assign sel_bin = slice[grant_idx];

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    grant_fire   = 1'b0;
    capture_fire = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          state_next = SETTLE;
          cnt_next   = 4'd0;
          grant_fire = 1'b1;
        end
      end
      SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          state_next   = CAPTURE;
          capture_fire = 1'b1;
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end
      CAPTURE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      last_grant <= 2'd3;
      owner      <= 2'd0;
      conv_bin   <= 14'd0;
      bcd_out    <= 16'd0;
      bcd_id     <= 2'd0;
      ack        <= 4'd0;
      bcd_valid  <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      ack       <= 4'd0;
      bcd_valid <= 1'b0;
      if (grant_fire) begin
        last_grant <= grant_idx;
        owner      <= grant_idx;
        conv_bin   <= load_bin;
      end
      if (capture_fire) begin
        bcd_out   <= {conv_thousands, conv_hundreds, conv_tens, conv_ones};
        bcd_id    <= owner;
        ack       <= 4'd1 << owner;
        bcd_valid <= 1'b1;
      end
    end
  end

`ifdef BCD_CONV_RANGE_CHK_EN
  logic range_flag;
  logic err_reg;

  assign load_bin = (sel_bin > 14'd9999) ? 14'd9999 : sel_bin;
  assign err      = err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      range_flag <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      if (grant_fire) range_flag <= (sel_bin > 14'd9999);
      err_reg <= capture_fire & range_flag;
    end
  end
`else
  assign load_bin = sel_bin;
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed bench for bcd_conv_arbiter: one SETTLE_CYCLES=1 instance and one SETTLE_CYCLES=3 instance,
// each paired with a behavioural binary-to-BCD converter.
module tb_bcd_conv_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  logic [3:0]  req = '0;
  logic [55:0] bin_in = '0;
  logic [3:0]  ack;
  logic [15:0] bcd_out;
  logic        bcd_valid, busy, err;
  logic [1:0]  bcd_id;
  logic [13:0] conv_bin;
  logic [3:0]  c_th, c_hu, c_te, c_on;

  logic [3:0]  req_3 = '0;
  logic [55:0] bin_in_3 = '0;
  logic [3:0]  ack_3;
  logic [15:0] bcd_out_3;
  logic        bcd_valid_3, busy_3, err_3;
  logic [1:0]  bcd_id_3;
  logic [13:0] conv_bin_3;
  logic [3:0]  c_th_3, c_hu_3, c_te_3, c_on_3;

  assign c_th = 4'((conv_bin / 14'd1000) % 14'd10);
  assign c_hu = 4'((conv_bin / 14'd100) % 14'd10);
  assign c_te = 4'((conv_bin / 14'd10) % 14'd10);
  assign c_on = 4'(conv_bin % 14'd10);

  assign c_th_3 = 4'((conv_bin_3 / 14'd1000) % 14'd10);
  assign c_hu_3 = 4'((conv_bin_3 / 14'd100) % 14'd10);
  assign c_te_3 = 4'((conv_bin_3 / 14'd10) % 14'd10);
  assign c_on_3 = 4'(conv_bin_3 % 14'd10);

  bcd_conv_arbiter #(.SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .bin_in(bin_in), .ack(ack),
    .bcd_out(bcd_out), .bcd_valid(bcd_valid), .bcd_id(bcd_id), .busy(busy),
    .err(err), .conv_bin(conv_bin), .conv_thousands(c_th), .conv_hundreds(c_hu),
    .conv_tens(c_te), .conv_ones(c_on)
  );

  bcd_conv_arbiter #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req_3), .bin_in(bin_in_3), .ack(ack_3),
    .bcd_out(bcd_out_3), .bcd_valid(bcd_valid_3), .bcd_id(bcd_id_3), .busy(busy_3),
    .err(err_3), .conv_bin(conv_bin_3), .conv_thousands(c_th_3), .conv_hundreds(c_hu_3),
    .conv_tens(c_te_3), .conv_ones(c_on_3)
  );

  // Counts falling edges until bcd_valid is seen; returns limit+1 on timeout.
  task automatic wait_valid(input int limit, output int k);
    k = 0;
    while (k <= limit) begin
      @(negedge clk);
      k++;
      if (bcd_valid) return;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    req = '0;
    req_3 = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ack, bcd_out, bcd_valid, bcd_id, busy, err, conv_bin} !== '0) begin
      n_mis++;
      $display("FAIL reset_outputs: got ack=%b bcd=%h v=%b id=%0d busy=%b err=%b conv=%0d, expected all zero",
               ack, bcd_out, bcd_valid, bcd_id, busy, err, conv_bin);
    end
    n_cmp++;
    if ({ack_3, bcd_out_3, bcd_valid_3, busy_3} !== '0) begin
      n_mis++;
      $display("FAIL reset_outputs_s3: got ack=%b bcd=%h v=%b busy=%b, expected all zero",
               ack_3, bcd_out_3, bcd_valid_3, busy_3);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int k;
    req = 4'b0001;
    bin_in[13:0] = 14'd2025;
    wait_valid(8, k);
    n_cmp++;
    if (k !== 3) begin n_mis++; $display("FAIL single_latency: got %0d cycles, expected 3", k); end
    n_cmp++;
    if (ack !== 4'b0001) begin n_mis++; $display("FAIL single_ack: got %b, expected 0001", ack); end
    n_cmp++;
    if (bcd_out !== 16'h2025) begin n_mis++; $display("FAIL single_bcd: got %h, expected 2025", bcd_out); end
    n_cmp++;
    if (bcd_id !== 2'd0) begin n_mis++; $display("FAIL single_id: got %0d, expected 0", bcd_id); end
    n_cmp++;
    if (conv_bin !== 14'd2025) begin n_mis++; $display("FAIL single_conv_bin: got %0d, expected 2025", conv_bin); end
    req = 4'b0000;
    @(negedge clk);
    n_cmp++;
    if ({ack, bcd_valid} !== 5'd0) begin n_mis++; $display("FAIL single_pulse_width: got ack=%b v=%b, expected 0", ack, bcd_valid); end
    $display("single conversion: req0 2025 -> %h after %0d cycles", 16'h2025, k);
  endtask

  task automatic test_idle_hold();
    bit bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy !== 1'b0 || ack !== 4'd0 || bcd_valid !== 1'b0 || bcd_out !== 16'h2025 ||
          bcd_id !== 2'd0 || conv_bin !== 14'd2025) bad = 1;
    end
    n_cmp++;
    if (bad) begin
      n_mis++;
      $display("FAIL idle_hold: got busy=%b ack=%b bcd=%h conv=%0d, expected 0/0/2025/2025", busy, ack, bcd_out, conv_bin);
    end
    $display("idle hold: outputs retained over 4 idle cycles");
  endtask

  task automatic test_round_robin();
    int k;
    logic [1:0]  exp_id  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [15:0] exp_bcd [5] = '{16'h0001, 16'h0022, 16'h0333, 16'h4444, 16'h0001};
    do_reset();
    bin_in = {14'd4444, 14'd333, 14'd22, 14'd1};
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_valid(10, k);
      n_cmp++;
      if (k !== ((j == 0) ? 3 : 4)) begin
        n_mis++;
        $display("FAIL rr_spacing[%0d]: got %0d cycles, expected %0d", j, k, (j == 0) ? 3 : 4);
      end
      n_cmp++;
      if (bcd_id !== exp_id[j] || ack !== (4'd1 << exp_id[j]) || bcd_out !== exp_bcd[j]) begin
        n_mis++;
        $display("FAIL rr_grant[%0d]: got id=%0d ack=%b bcd=%h, expected id=%0d bcd=%h",
                 j, bcd_id, ack, bcd_out, exp_id[j], exp_bcd[j]);
      end
      $display("round robin %0d: id=%0d bcd=%h", j, bcd_id, bcd_out);
    end
    req = 4'b0000;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_input_sampling();
    int k;
    do_reset();
    bin_in = '0;
    bin_in[41:28] = 14'd59;
    req = 4'b0100;
    @(negedge clk);
    bin_in[41:28] = 14'd7;
    req = 4'b0000;
    wait_valid(8, k);
    n_cmp++;
    if (k !== 2) begin n_mis++; $display("FAIL sample_latency: got %0d, expected 2", k); end
    n_cmp++;
    if (bcd_out !== 16'h0059 || bcd_id !== 2'd2 || ack !== 4'b0100) begin
      n_mis++;
      $display("FAIL sample_hold: got bcd=%h id=%0d ack=%b, expected 0059/2/0100", bcd_out, bcd_id, ack);
    end
    $display("input sampling: bcd=%h id=%0d", bcd_out, bcd_id);
  endtask

  task automatic test_reset_mid();
    int k;
    bit acked = 0;
    do_reset();
    bin_in = '0;
    bin_in[13:0] = 14'd2025;
    req = 4'b0001;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ack, bcd_out, bcd_valid, bcd_id, busy, err, conv_bin} !== '0) begin
      n_mis++;
      $display("FAIL reset_mid_outputs: got busy=%b conv=%0d bcd=%h ack=%b, expected all zero", busy, conv_bin, bcd_out, ack);
    end
    repeat (3) begin
      @(negedge clk);
      if (ack !== 4'd0 || bcd_valid !== 1'b0) acked = 1;
    end
    n_cmp++;
    if (acked) begin n_mis++; $display("FAIL reset_mid_noack: got an ack during reset, expected none"); end
    bin_in = '0;
    bin_in[13:0] = 14'd5;
    bin_in[55:42] = 14'd77;
    req = 4'b1001;
    rst_n = 1'b1;
    wait_valid(8, k);
    req = 4'b0000;
    n_cmp++;
    if (k !== 3 || bcd_id !== 2'd0 || bcd_out !== 16'h0005) begin
      n_mis++;
      $display("FAIL reset_mid_regrant: got k=%0d id=%0d bcd=%h, expected 3/0/0005", k, bcd_id, bcd_out);
    end
    $display("reset mid conversion: first grant after release id=%0d", bcd_id);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_range();
    int k;
    logic [13:0] exp_conv;
    logic        exp_err;
`ifdef BCD_CONV_RANGE_CHK_EN
    exp_conv = 14'd9999;
    exp_err  = 1'b1;
`else
    exp_conv = 14'd12000;
    exp_err  = 1'b0;
`endif
    do_reset();
    bin_in = '0;
    bin_in[27:14] = 14'd12000;
    req = 4'b0010;
    @(negedge clk);
    req = 4'b0000;
    n_cmp++;
    if (conv_bin !== exp_conv) begin n_mis++; $display("FAIL range_conv_bin: got %0d, expected %0d", conv_bin, exp_conv); end
    wait_valid(8, k);
    n_cmp++;
    if (err !== exp_err || bcd_valid !== 1'b1) begin
      n_mis++;
      $display("FAIL range_err: got err=%b v=%b, expected err=%b v=1", err, bcd_valid, exp_err);
    end
`ifdef BCD_CONV_RANGE_CHK_EN
    n_cmp++;
    if (bcd_out !== 16'h9999) begin n_mis++; $display("FAIL range_bcd: got %h, expected 9999", bcd_out); end
`endif
    @(negedge clk);
    n_cmp++;
    if (err !== 1'b0) begin n_mis++; $display("FAIL range_err_pulse: got %b, expected 0", err); end
    $display("range: conv_bin=%0d err_expected=%b", exp_conv, exp_err);
  endtask

  task automatic test_settle3();
    bit bad_busy = 0;
    bit bad_ack = 0;
    do_reset();
    bin_in_3 = '0;
    bin_in_3[41:28] = 14'd1234;
    req_3 = 4'b0100;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) req_3 = 4'b0000;
      if (busy_3 !== (k <= 5)) bad_busy = 1;
      if (ack_3 !== ((k == 5) ? 4'b0100 : 4'b0000) || bcd_valid_3 !== (k == 5)) bad_ack = 1;
      if (k == 5) begin
        n_cmp++;
        if (bcd_out_3 !== 16'h1234 || bcd_id_3 !== 2'd2) begin
          n_mis++;
          $display("FAIL settle3_data: got bcd=%h id=%0d, expected 1234/2", bcd_out_3, bcd_id_3);
        end
      end
    end
    n_cmp++;
    if (bad_busy) begin n_mis++; $display("FAIL settle3_busy: got busy profile wrong, expected high for cycles 1..5 only"); end
    n_cmp++;
    if (bad_ack) begin n_mis++; $display("FAIL settle3_ack: got ack outside cycle 5 or missing, expected only at cycle 5"); end
    $display("settle 3: ack at cycle 5, bcd=%h", bcd_out_3);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_single();
    test_idle_hold();
    test_round_robin();
    test_input_sampling();
    test_reset_mid();
    test_range();
    test_settle3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
